// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the MIPS datapath/memories.
// The controller takes the master side; the datapath/memory model takes the slave side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       IRWr;
  logic       PCWr;
  logic [1:0] NPCOp;
  logic [2:0] ALUOp;
  logic [1:0] A3WRSel;
  logic [1:0] WDSel;
  logic       EXTOp;
  logic       RFWE;
  logic       ALUBSel;
  logic       DMWr;
  logic       err;
  logic [2:0] state;

  modport master (
    input  opcode, funct, Zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, IRWr, PCWr, NPCOp, ALUOp, A3WRSel, WDSel,
           EXTOp, RFWE, ALUBSel, DMWr, err, state
  );

  modport slave (
    output opcode, funct, Zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, IRWr, PCWr, NPCOp, ALUOp, A3WRSel, WDSel,
           EXTOp, RFWE, ALUBSel, DMWr, err, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS datapath with
// req/ready memory handshakes and a sticky per-access timeout trap.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_UND, I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL
  } instr_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t     r_state, w_next;
  logic [7:0] r_wcnt, w_wcnt_nxt;
  instr_t     w_ins;
  logic [2:0] w_aluop;
  logic       w_alub, w_ext;

  logic       w_imreq, w_dmreq, w_irwr, w_pcwr, w_rfwe, w_dmwr, w_err;
  logic [1:0] w_npc, w_a3, w_wd;
  logic [2:0] w_aluop_o;
  logic       w_alub_o, w_ext_o;

  always_comb begin
    w_ins = I_UND;
    case (bus.opcode)
      6'h00: begin
        case (bus.funct)
          6'h21:   w_ins = I_ADDU;
          6'h23:   w_ins = I_SUBU;
          6'h08:   w_ins = I_JR;
          default: w_ins = I_UND;
        endcase
      end
      6'h0D:   w_ins = I_ORI;
      6'h23:   w_ins = I_LW;
      6'h2B:   w_ins = I_SW;
      6'h04:   w_ins = I_BEQ;
      6'h0F:   w_ins = I_LUI;
      6'h03:   w_ins = I_JAL;
      default: w_ins = I_UND;
    endcase
  end

  // Datapath steering per instruction; only meaningful from DECODE onward.
  always_comb begin
    w_aluop = 3'b000;
    w_alub  = 1'b0;
    w_ext   = 1'b0;
    case (w_ins)
      I_SUBU:     w_aluop = 3'b001;
      I_ORI:      begin w_aluop = 3'b010; w_alub = 1'b1; end
      I_LW, I_SW: begin w_alub = 1'b1; w_ext = 1'b1; end
      I_BEQ:      begin w_aluop = 3'b001; w_ext = 1'b1; end
      I_LUI:      begin w_aluop = 3'b011; w_alub = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Counter defaults to zero, so it is clear on entry to FETCH/MEM and on ready.
  always_comb begin
    w_next     = r_state;
    w_wcnt_nxt = '0;
    w_imreq    = 1'b0;
    w_dmreq    = 1'b0;
    w_irwr     = 1'b0;
    w_pcwr     = 1'b0;
    w_rfwe     = 1'b0;
    w_dmwr     = 1'b0;
    w_err      = 1'b0;
    w_npc      = 2'b00;
    w_a3       = 2'b00;
    w_wd       = 2'b00;
    w_aluop_o  = 3'b000;
    w_alub_o   = 1'b0;
    w_ext_o    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imreq = 1'b1;
        if (bus.imem_ready) begin
          w_irwr = 1'b1;
          w_next = S_DECODE;
        end else if (r_wcnt == LIMIT) begin
          w_next = S_ERR;
        end else begin
          w_wcnt_nxt = r_wcnt + 8'd1;
        end
      end
      S_DECODE: begin
        w_ext_o = w_ext;
        w_next  = S_EXE;
      end
      S_EXE: begin
        w_aluop_o = w_aluop;
        w_alub_o  = w_alub;
        w_ext_o   = w_ext;
        case (w_ins)
          I_BEQ: begin
            w_pcwr = 1'b1;
            w_npc  = bus.Zero ? 2'b01 : 2'b00;
            w_next = S_FETCH;
          end
          I_JR: begin
            w_pcwr = 1'b1;
            w_npc  = 2'b11;
            w_next = S_FETCH;
          end
          I_UND: begin
            w_pcwr = 1'b1;
            w_next = S_FETCH;
          end
          I_LW, I_SW: w_next = S_MEM;
          default:    w_next = S_WB;
        endcase
      end
      S_MEM: begin
        w_dmreq   = 1'b1;
        w_aluop_o = w_aluop;
        w_alub_o  = w_alub;
        w_ext_o   = w_ext;
        w_dmwr    = (w_ins == I_SW);
        if (bus.dmem_ready) begin
          if (w_ins == I_SW) begin
            w_pcwr = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (r_wcnt == LIMIT) begin
          w_next = S_ERR;
        end else begin
          w_wcnt_nxt = r_wcnt + 8'd1;
        end
      end
      S_WB: begin
        w_rfwe    = 1'b1;
        w_pcwr    = 1'b1;
        w_aluop_o = w_aluop;
        w_alub_o  = w_alub;
        w_ext_o   = w_ext;
        w_next    = S_FETCH;
        case (w_ins)
          I_ADDU, I_SUBU: w_a3 = 2'b01;
          I_LW:           w_wd = 2'b01;
          I_JAL: begin
            w_a3  = 2'b10;
            w_wd  = 2'b10;
            w_npc = 2'b10;
          end
          default: ;
        endcase
      end
      S_ERR: begin
        w_err  = 1'b1;
        w_next = S_ERR;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Everything is forced low while reset is asserted, independent of the clock.
  assign bus.imem_req = w_imreq & reset;
  assign bus.dmem_req = w_dmreq & reset;
  assign bus.IRWr     = w_irwr & reset;
  assign bus.PCWr     = w_pcwr & reset;
  assign bus.RFWE     = w_rfwe & reset;
  assign bus.DMWr     = w_dmwr & reset;
  assign bus.err      = w_err & reset;
  assign bus.NPCOp    = reset ? w_npc : 2'b00;
  assign bus.A3WRSel  = reset ? w_a3 : 2'b00;
  assign bus.WDSel    = reset ? w_wd : 2'b00;
  assign bus.ALUOp    = reset ? w_aluop_o : 3'b000;
  assign bus.ALUBSel  = w_alub_o & reset;
  assign bus.EXTOp    = w_ext_o & reset;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream against an instruction-level model of the
// multi-cycle sequencer; one negedge process compares every planned cycle.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  localparam int K_UND = 0, K_ADDU = 1, K_SUBU = 2, K_JR = 3, K_ORI = 4;
  localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_LUI = 8, K_JAL = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;

  multicycle_ctrl_if bus ();
  multicycle_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       im;
    logic       dm;
    logic       z;
    logic [2:0] st;
    logic       imreq;
    logic       dmreq;
    logic       irwr;
    logic       pcwr;
    logic       rfwe;
    logic       dmwr;
    logic       err;
    logic [1:0] npc;
    logic [2:0] aluop;
    logic       alub;
    logic [1:0] a3;
    logic [1:0] wd;
    logic       ext;
    logic       c_alu;
    logic       c_ext;
  } cyc_t;

  cyc_t q[$];
  cyc_t ex;
  bit   chk = 1'b0;
  int   checks = 0;
  int   fails = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("state", 32'(bus.state), 32'(ex.st));
      cmp("imem_req", 32'(bus.imem_req), 32'(ex.imreq));
      cmp("dmem_req", 32'(bus.dmem_req), 32'(ex.dmreq));
      cmp("IRWr", 32'(bus.IRWr), 32'(ex.irwr));
      cmp("PCWr", 32'(bus.PCWr), 32'(ex.pcwr));
      cmp("RFWE", 32'(bus.RFWE), 32'(ex.rfwe));
      cmp("DMWr", 32'(bus.DMWr), 32'(ex.dmwr));
      cmp("err", 32'(bus.err), 32'(ex.err));
      if (ex.pcwr) cmp("NPCOp", 32'(bus.NPCOp), 32'(ex.npc));
      if (ex.rfwe) begin
        cmp("A3WRSel", 32'(bus.A3WRSel), 32'(ex.a3));
        cmp("WDSel", 32'(bus.WDSel), 32'(ex.wd));
      end
      if (ex.c_alu) begin
        cmp("ALUOp", 32'(bus.ALUOp), 32'(ex.aluop));
        cmp("ALUBSel", 32'(bus.ALUBSel), 32'(ex.alub));
      end
      if (ex.c_ext) cmp("EXTOp", 32'(bus.EXTOp), 32'(ex.ext));
    end
  end

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU : (fn == 6'h08) ? K_JR : K_UND;
      6'h0D: return K_ORI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h0F: return K_LUI;
      6'h03: return K_JAL;
      default: return K_UND;
    endcase
  endfunction

  // A cycle with every strobe expected low and the don't-care inputs randomized.
  function automatic cyc_t blank(input logic [2:0] st, input logic [5:0] op, input logic [5:0] fn);
    cyc_t c;
    c    = '0;
    c.st = st;
    c.op = op;
    c.fn = fn;
    c.im = 1'($urandom_range(1));
    c.dm = 1'($urandom_range(1));
    c.z  = 1'($urandom_range(1));
    return c;
  endfunction

  // Expected cycle list for one instruction: wi fetch waits, wd memory waits.
  task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int wi, input int wd,
                      input logic zexe, output bit hit_err);
    int k;
    cyc_t c;
    logic [2:0] aop;
    logic ab, ae, ca, ce;
    k = kind_of(op, fn);
    hit_err = 1'b0;
    aop = 3'b000; ab = 1'b0; ae = 1'b0; ca = 1'b1; ce = 1'b0;
    case (k)
      K_ADDU: ;
      K_SUBU: aop = 3'b001;
      K_ORI:  begin aop = 3'b010; ab = 1'b1; ce = 1'b1; end
      K_LW, K_SW: begin ab = 1'b1; ae = 1'b1; ce = 1'b1; end
      K_BEQ:  aop = 3'b001;
      K_LUI:  begin aop = 3'b011; ab = 1'b1; end
      default: ca = 1'b0;
    endcase
    for (int i = 0; i <= wi; i++) begin
      c = blank(3'd0, 6'($urandom), 6'($urandom));
      c.imreq = 1'b1;
      c.im = (i == wi);
      c.irwr = (i == wi);
      q.push_back(c);
      if (i != wi && i == TO - 1) begin hit_err = 1'b1; return; end
    end
    c = blank(3'd1, op, fn);
    c.c_ext = ce; c.ext = ae;
    q.push_back(c);
    c = blank(3'd2, op, fn);
    c.z = zexe; c.c_ext = ce; c.ext = ae; c.c_alu = ca; c.aluop = aop; c.alub = ab;
    case (k)
      K_BEQ: begin c.pcwr = 1'b1; c.npc = zexe ? 2'b01 : 2'b00; end
      K_JR:  begin c.pcwr = 1'b1; c.npc = 2'b11; end
      K_UND: begin c.pcwr = 1'b1; c.npc = 2'b00; end
      default: ;
    endcase
    q.push_back(c);
    if (k == K_BEQ || k == K_JR || k == K_UND) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= wd; i++) begin
        c = blank(3'd3, op, fn);
        c.dmreq = 1'b1; c.c_ext = ce; c.ext = ae; c.c_alu = 1'b1; c.aluop = aop; c.alub = ab;
        c.dmwr = (k == K_SW);
        c.dm = (i == wd);
        if (i == wd && k == K_SW) begin c.pcwr = 1'b1; c.npc = 2'b00; end
        q.push_back(c);
        if (i != wd && i == TO - 1) begin hit_err = 1'b1; return; end
      end
      if (k == K_SW) return;
    end
    c = blank(3'd4, op, fn);
    c.rfwe = 1'b1; c.pcwr = 1'b1; c.c_ext = ce; c.ext = ae;
    case (k)
      K_ADDU, K_SUBU: c.a3 = 2'b01;
      K_LW:           c.wd = 2'b01;
      K_JAL:          begin c.a3 = 2'b10; c.wd = 2'b10; c.npc = 2'b10; end
      default: ;
    endcase
    q.push_back(c);
  endtask

  task automatic push_err(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(3'd7, 6'($urandom), 6'($urandom));
      c.err = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic drive(input cyc_t c);
    bus.opcode = c.op;
    bus.funct = c.fn;
    bus.Zero = c.z;
    bus.imem_ready = c.im;
    bus.dmem_ready = c.dm;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) begin
      ex = q.pop_front();
      drive(ex);
      chk = 1'b1;
      @(posedge clk);
      #1;
    end
    chk = 1'b0;
  endtask

  task automatic run_q();
    run_n(q.size());
  endtask

  task automatic check_zero(input string nm);
    cmp(nm, 32'({bus.imem_req, bus.dmem_req, bus.IRWr, bus.PCWr, bus.NPCOp, bus.ALUOp,
                 bus.A3WRSel, bus.WDSel, bus.EXTOp, bus.RFWE, bus.ALUBSel, bus.DMWr, bus.err}), 32'd0);
    cmp({nm, "_state"}, 32'(bus.state), 32'd0);
  endtask

  task automatic reset_pulse(input string nm);
    reset = 1'b0;
    #1;
    check_zero(nm);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [5:0] op_tab [0:9] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h03, 6'h00};
  logic [5:0] fn_tab [0:9] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    bit e;
    logic [5:0] op, fn;
    bus.opcode = 6'h23; bus.funct = 6'h00; bus.Zero = 1'b1;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    plan(6'h00, 6'h21, 0, 0, 1'b0, e);
    cmp("model_addu_len", q.size(), 4);
    cmp("model_addu_a3", 32'(q[3].a3), 32'd1);
    run_q();
    plan(6'h23, 6'h00, 0, 3, 1'b0, e);
    cmp("model_lw_len", q.size(), 8);
    cmp("model_lw_wd", 32'(q[7].wd), 32'd1);
    run_q();
    plan(6'h04, 6'h00, 0, 0, 1'b1, e);
    cmp("model_beq1_len", q.size(), 3);
    cmp("model_beq1_npc", 32'(q[2].npc), 32'd1);
    run_q();
    plan(6'h04, 6'h00, 0, 0, 1'b0, e);
    run_q();
    plan(6'h03, 6'h00, 0, 0, 1'b0, e);
    cmp("model_jal_npc", 32'(q[3].npc), 32'd2);
    run_q();
    plan(6'h3F, 6'h00, 0, 0, 1'b0, e);
    cmp("model_und_len", q.size(), 3);
    run_q();
    plan(6'h2B, 6'h00, 0, 0, 1'b0, e);
    cmp("model_sw_len", q.size(), 4);
    run_q();
    plan(6'h0D, 6'h00, TO - 1, 0, 1'b0, e);
    cmp("model_ori_edge", 32'(e), 32'd0);
    run_q();

    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(11);
      if (sel < 10) begin op = op_tab[sel]; fn = fn_tab[sel]; end
      else begin op = 6'($urandom); fn = 6'($urandom); end
      plan(op, fn, $urandom_range(TO - 1), $urandom_range(TO - 1), 1'($urandom_range(1)), e);
      run_q();
    end

    // sw aborted by reset in its second MEM cycle
    plan(6'h2B, 6'h00, 0, 5, 1'b0, e);
    run_n(4);
    ex = q.pop_front();
    drive(ex);
    #2;
    cmp("abort_dmem_req", 32'(bus.dmem_req), 32'd1);
    cmp("abort_DMWr", 32'(bus.DMWr), 32'd1);
    reset = 1'b0;
    #1;
    check_zero("abort_async");
    q.delete();
    bus.imem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    cmp("abort_imem_req", 32'(bus.imem_req), 32'd1);
    cmp("abort_PCWr", 32'(bus.PCWr), 32'd0);
    plan(6'h00, 6'h23, 1, 0, 1'b0, e);
    run_q();

    plan(6'h00, 6'h21, 20, 0, 1'b0, e);
    cmp("model_fetch_to", 32'(e), 32'd1);
    cmp("model_fetch_to_len", q.size(), TO);
    push_err(8);
    run_q();
    reset_pulse("err_fetch_reset");
    plan(6'h0F, 6'h00, 0, 0, 1'b0, e);
    run_q();

    plan(6'h23, 6'h00, 0, 20, 1'b0, e);
    cmp("model_mem_to", 32'(e), 32'd1);
    push_err(6);
    run_q();
    reset_pulse("err_mem_reset");
    plan(6'h00, 6'h08, 2, 0, 1'b0, e);
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
